// File: rtl/kamus_pkg.sv
// kamus_pkg: kamus-v control types, control-unit FSM states and memory-op helpers
package kamus_pkg;
   typedef enum logic [5:0] {
      LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU, SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
   } operation_e;
   typedef enum logic [1:0] {PC_ST, J_ST, B_ST} instr_addr_state_e;
   typedef enum logic [1:0] {ALU_RESULT, NEXT_PC, MEM_DATA} wb_sel_e;
   typedef enum logic [2:0] {RUN, MEM_REQ, MEM_WAIT, FLUSH, DRAIN, ERR} cu_state_e;
   typedef struct packed {
      operation_e        operation;
      instr_addr_state_e instr_addr_state;
      wb_sel_e           wb_sel;
      logic              l1d_wr_en;
      logic              regfile_wr_en;
   } control_unit_t;
   function automatic logic is_load(operation_e op);
      return op inside {LB, LH, LW, LBU, LHU};
   endfunction
   function automatic logic is_store(operation_e op);
      return op inside {SB, SH, SW};
   endfunction
   function automatic logic is_branch(operation_e op);
      return op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
   endfunction
endpackage

// File: rtl/kamus_cu_seq_if.sv
// kamus_cu_seq_if: L1D request/grant/response handshake; master drives req, slave drives gnt and rvalid
interface kamus_cu_seq_if;
   logic req;
   logic gnt;
   logic rvalid;
   modport master (output req, input gnt, input rvalid);
   modport slave (input req, output gnt, output rvalid);
endinterface

// File: rtl/kamus_cu_timeout.sv
// kamus_cu_timeout: loadable saturating down-counter; ports clk_i, rst_ni, start_i (load load_i and arm), clear_i (disarm), expired_o (armed and at zero)
module kamus_cu_timeout #(
   parameter int W = 7
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         clear_i,
   input  logic [W-1:0] load_i,
   output logic         expired_o
);
   logic [W-1:0] cnt_q, cnt_d;
   logic         armed_q, armed_d;
   always_comb begin
      cnt_d   = start_i ? load_i : cnt_q != '0 ? cnt_q - W'(1) : cnt_q;
      armed_d = start_i || (armed_q && !clear_i);
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end
   assign expired_o = armed_q && cnt_q == '0;
endmodule

// File: rtl/kamus_cu_seq.sv
// kamus_cu_seq: decode FSM for datapath control; ports clk_i/rst_ni, instr_valid_i, control_unit_i/o, branch_taken_i, kill_i, l1d (req/gnt/rvalid master), stall_o, flush_o, bus_err_o, stall_cnt_o/flush_cnt_o (counting only with KAMUS_CU_PERF_CNT_EN)
module kamus_cu_seq
   import kamus_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 64,
   parameter int FLUSH_CYCLES = 2,
   parameter int PERF_CNT_W   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  instr_valid_i,
   input  control_unit_t         control_unit_i,
   input  logic                  branch_taken_i,
   input  logic                  kill_i,
   kamus_cu_seq_if.master        l1d,
   output control_unit_t         control_unit_o,
   output logic                  stall_o,
   output logic                  flush_o,
   output logic                  bus_err_o,
   output logic [PERF_CNT_W-1:0] stall_cnt_o,
   output logic [PERF_CNT_W-1:0] flush_cnt_o
);
   localparam int TW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TLOAD = TW'(MEM_TIMEOUT > 1 ? MEM_TIMEOUT - 2 : 0);
   cu_state_e  state_q, state_d;
   logic       st_q, st_d;
   logic [2:0] fcnt_q, fcnt_d;
   operation_e op;
   logic       go, jmp, br, mem, expired, tmo, tmo_start, tmo_clear;
   assign op  = control_unit_i.operation;
   assign go  = instr_valid_i && !kill_i;
   assign jmp = go && op inside {JAL, JALR};
   assign br  = go && is_branch(op) && branch_taken_i;
   assign mem = go && (is_load(op) || is_store(op));
   assign tmo = MEM_TIMEOUT != 0 && expired;
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      fcnt_d  = fcnt_q;
      control_unit_o                  = control_unit_i;
      control_unit_o.instr_addr_state = PC_ST;
      control_unit_o.wb_sel           = ALU_RESULT;
      control_unit_o.l1d_wr_en        = 1'b0;
      control_unit_o.regfile_wr_en    = 1'b0;
      l1d.req   = 1'b0;
      stall_o   = 1'b0;
      flush_o   = 1'b0;
      bus_err_o = 1'b0;
      case (state_q)
         RUN: begin
            control_unit_o.regfile_wr_en    = go && op inside {LUI, AUIPC, JAL, JALR};
            control_unit_o.wb_sel           = jmp ? NEXT_PC : ALU_RESULT;
            control_unit_o.instr_addr_state = jmp ? J_ST : br ? B_ST : PC_ST;
            control_unit_o.l1d_wr_en        = mem && is_store(op);
            l1d.req = mem;
            stall_o = mem;
            flush_o = jmp || br;
            st_d    = is_store(op);
            fcnt_d  = 3'd1;
            // a one-cycle timeout has already expired by the end of the issue cycle
            state_d = (jmp || br) ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) :
                      !mem ? RUN : MEM_TIMEOUT == 1 ? ERR : l1d.gnt ? MEM_WAIT : MEM_REQ;
         end
         MEM_REQ: begin
            // a grant coinciding with kill completes the handshake, so its response must be drained
            l1d.req = !kill_i || l1d.gnt;
            stall_o = !kill_i || l1d.gnt;
            control_unit_o.l1d_wr_en = st_q && (!kill_i || l1d.gnt);
            state_d = kill_i ? (l1d.gnt ? DRAIN : RUN) : tmo ? ERR : l1d.gnt ? MEM_WAIT : MEM_REQ;
         end
         MEM_WAIT: begin
            stall_o = !l1d.rvalid;
            control_unit_o.regfile_wr_en = l1d.rvalid && !kill_i && !st_q;
            control_unit_o.wb_sel = l1d.rvalid && !kill_i && !st_q ? MEM_DATA : ALU_RESULT;
            state_d = l1d.rvalid ? RUN : kill_i ? DRAIN : tmo ? ERR : MEM_WAIT;
         end
         DRAIN: begin
            stall_o = !l1d.rvalid;
            state_d = l1d.rvalid ? RUN : DRAIN;
         end
         FLUSH: begin
            flush_o = !kill_i;
            fcnt_d  = fcnt_q + 3'd1;
            state_d = kill_i || fcnt_q + 3'd1 >= 3'(FLUSH_CYCLES) ? RUN : FLUSH;
         end
         ERR: begin
            bus_err_o = 1'b1;
            flush_o   = 1'b1;
            state_d   = RUN;
         end
         default: state_d = RUN;
      endcase
   end
   assign tmo_start = state_q == RUN && state_d inside {MEM_REQ, MEM_WAIT};
   assign tmo_clear = !(state_d inside {MEM_REQ, MEM_WAIT});
   kamus_cu_timeout #(.W(TW)) u_timeout (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (tmo_start),
      .clear_i   (tmo_clear),
      .load_i    (TLOAD),
      .expired_o (expired)
   );
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= RUN;
         st_q    <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         fcnt_q  <= fcnt_d;
      end
   end
`ifdef KAMUS_CU_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   always_comb begin
      stall_cnt_d = stall_cnt_q + PERF_CNT_W'(stall_o);
      // a flush event is the first flushing cycle of a burst: branch/jump decode or ERR
      flush_cnt_d = flush_cnt_q + PERF_CNT_W'(flush_o && state_q != FLUSH);
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif
endmodule
